// File: rtl/obstacle_pkg.sv
// ---------------------------------------------------------------------------
// obstacle_pkg
//
// Purpose : Shared constants and types for the obstacle lane generator.
//
// Contents:
//   OBST_WIDTH_DEFAULT   - default number of lane cells
//   OBST_MIN_GAP_DEFAULT - default minimum empty cells between inserted obstacles
//   obst_lane_t          - lane map type at the default width
//
// Configuration macro: OBSTACLE_MIN_GAP_EN (consumed by obstacle_spawn_gate).
// ---------------------------------------------------------------------------
package obstacle_pkg;

    localparam int unsigned OBST_WIDTH_DEFAULT   = 10;
    localparam int unsigned OBST_MIN_GAP_DEFAULT = 2;

    // Bit 0 is the spawn cell; bit OBST_WIDTH_DEFAULT-1 is the last cell before exit.
    typedef logic [OBST_WIDTH_DEFAULT-1:0] obst_lane_t;

endpackage

// File: rtl/obstacle_spawn_gate.sv
// ---------------------------------------------------------------------------
// obstacle_spawn_gate
//
// Purpose : Decides whether a requested obstacle is actually inserted into
//           the spawn cell on the next enabled shift.
//
// Ports:
//   rng_in - request bit, 1 asks for a new obstacle
//   lane   - current registered lane map (bit 0 = most recent cell)
//   ins    - qualified insert bit
//
// Configuration macro: OBSTACLE_MIN_GAP_EN
//   defined   : a request is granted only when the MIN_GAP most recently
//               shifted-in cells are all empty; a refused request is dropped
//   undefined : every request is granted and MIN_GAP is unused
//
// Purely combinational; the caller registers the result.
// ---------------------------------------------------------------------------
module obstacle_spawn_gate
    import obstacle_pkg::*;
#(
    parameter int unsigned WIDTH   = OBST_WIDTH_DEFAULT,
    parameter int unsigned MIN_GAP = OBST_MIN_GAP_DEFAULT
) (
    input  logic             rng_in,
    input  logic [WIDTH-1:0] lane,
    output logic             ins
);

`ifdef OBSTACLE_MIN_GAP_EN

    if (MIN_GAP < 1 || MIN_GAP > WIDTH - 1) begin : g_bad_gap
        $error("obstacle_spawn_gate: MIN_GAP must be in 1..WIDTH-1");
    end

    logic recent_clear;

    // Only the youngest MIN_GAP cells matter; anything older already has the gap.
    assign recent_clear = (lane[MIN_GAP-1:0] == '0);
    assign ins          = rng_in & recent_clear;

`else

    // Lane is not needed without gap qualification.
    logic unused_lane;

    assign unused_lane = ^lane;
    assign ins         = rng_in;

`endif

endmodule

// File: rtl/obstacle_generator.sv
// ---------------------------------------------------------------------------
// obstacle_generator
//
// Purpose : Obstacle lane shift register. Each enabled clock shifts the lane
//           one cell towards the exit and fills the spawn cell with the
//           qualified insert bit. The oldest cell falls off the end, so each
//           obstacle is visible for exactly WIDTH enabled cycles.
//
// Ports:
//   clk       - rising-edge clock
//   rst       - synchronous, active-high reset; clears the lane, beats en
//   en        - advance enable; when low the lane holds and rng_in is ignored
//   rng_in    - request bit for a new obstacle this cycle
//   obstacles - registered lane map, bit 0 = spawn cell, 1 = obstacle
//
// Configuration macro: OBSTACLE_MIN_GAP_EN (see obstacle_spawn_gate).
//
// The lane register is the only state; gap qualification is derived from it.
// ---------------------------------------------------------------------------
module obstacle_generator
    import obstacle_pkg::*;
#(
    parameter int unsigned WIDTH   = OBST_WIDTH_DEFAULT,
    parameter int unsigned MIN_GAP = OBST_MIN_GAP_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             rng_in,
    output logic [WIDTH-1:0] obstacles
);

    logic [WIDTH-1:0] lane_q;
    logic [WIDTH-1:0] lane_d;
    logic             ins;

    obstacle_spawn_gate #(
        .WIDTH   (WIDTH),
        .MIN_GAP (MIN_GAP)
    ) u_spawn_gate (
        .rng_in (rng_in),
        .lane   (lane_q),
        .ins    (ins)
    );

    always_comb begin
        lane_d = lane_q;
        if (en) begin
            lane_d = {lane_q[WIDTH-2:0], ins};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lane_q <= '0;
        end else begin
            lane_q <= lane_d;
        end
    end

    // Straight from the flops: no input reaches the output combinationally.
    assign obstacles = lane_q;

endmodule

// File: tb/tb_obstacle_generator.sv
// ---------------------------------------------------------------------------
// tb_obstacle_generator
//
// Directed and randomized checks of obstacle_generator at the default size.
// The reference model tracks the age of every live obstacle (enabled cycles
// since insertion) and rebuilds the expected lane map from those ages.
// Honours OBSTACLE_MIN_GAP_EN the same way the design build does.
// ---------------------------------------------------------------------------
module tb_obstacle_generator;
    import obstacle_pkg::*;

    localparam int unsigned W   = OBST_WIDTH_DEFAULT;
    localparam int unsigned GAP = OBST_MIN_GAP_DEFAULT;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic       rng_in;
    obst_lane_t obstacles;

    int vectors = 0;
    int errors  = 0;

    // Ages of live obstacles; age 0 sits in the spawn cell.
    int ages[$];

    obstacle_generator #(
        .WIDTH   (W),
        .MIN_GAP (GAP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .rng_in    (rng_in),
        .obstacles (obstacles)
    );

    always #5 clk = ~clk;

    function automatic obst_lane_t model_map();
        obst_lane_t m = '0;
        foreach (ages[i]) m[ages[i]] = 1'b1;
        return m;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic g);
        int  kept[$];
        bit  blocked = 0;
        if (r) begin
            ages.delete();
        end else if (e) begin
`ifdef OBSTACLE_MIN_GAP_EN
            foreach (ages[i]) if (ages[i] < int'(GAP)) blocked = 1;
`endif
            foreach (ages[i]) if (ages[i] + 1 < int'(W)) kept.push_back(ages[i] + 1);
            ages = kept;
            if (g && !blocked) ages.push_back(0);
        end
    endtask

    task automatic check(input string tag, input obst_lane_t exp);
        vectors++;
        assert (obstacles === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obstacles, exp);
        end
    endtask

    // One clock edge: drive, clock, sample 1 time unit later, compare to model.
    task automatic step(input logic r, input logic e, input logic g);
        rst    = r;
        en     = e;
        rng_in = g;
        @(posedge clk);
        #1;
        model_step(r, e, g);
        check("model", model_map());
    endtask

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        rng_in = 1'b0;
        @(posedge clk);
        #1;

        // Reset beats en and rng_in.
        step(1'b1, 1'b1, 1'b1);
        check("reset", 10'b0000000000);

        // Back-to-back requests from an empty lane.
        step(1'b0, 1'b1, 1'b1);
        check("burst1", 10'b0000000001);
        step(1'b0, 1'b1, 1'b1);
`ifdef OBSTACLE_MIN_GAP_EN
        check("gap2", 10'b0000000010);
        step(1'b0, 1'b1, 1'b1);
        check("gap3", 10'b0000000100);
        step(1'b0, 1'b1, 1'b1);
        check("gap4", 10'b0000001001);
`else
        check("nogap2", 10'b0000000011);
        step(1'b0, 1'b1, 1'b1);
        check("nogap3", 10'b0000000111);
`endif

        // Hold while disabled; requests are ignored.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("hold_pre", 10'b0000000001);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b1);
            check("hold", 10'b0000000001);
        end

        // Single obstacle walks off the end after exactly W enabled cycles.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        for (int i = 1; i <= 10; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (i == 9)  check("exit9", 10'b1000000000);
            if (i == 10) check("exit10", 10'b0000000000);
        end

        // Mid-run reset clears the lane; next enabled edge may insert at once.
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
`ifndef OBSTACLE_MIN_GAP_EN
        check("pattern", 10'b0000101001);
`endif
        step(1'b1, 1'b1, 1'b1);
        check("midreset", 10'b0000000000);
        step(1'b0, 1'b1, 1'b1);
        check("post_reset", 10'b0000000001);

        // Randomized run against the model.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) != 0),
                 ($urandom_range(0, 2) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/obstacle_generator.md
OBSTACLE_GENERATOR -- requirements
Module: obstacle_generator

Interface
REQ-001 Parameter WIDTH, default 10; number of obstacle lane cells.
REQ-002 Parameter MIN_GAP, default 2; minimum empty cells between successive inserted obstacles, legal range 1..WIDTH-1.
REQ-003 clk  input  1  single rising-edge clock.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 en  input  1  advance enable; lane shifts one cell per clk while high.
REQ-006 rng_in  input  1  random request bit; 1 requests a new obstacle this cycle.
REQ-007 obstacles  output  WIDTH  registered lane map:
- bit 0 = spawn cell;
- bit WIDTH-1 = last cell before exit;
- 1 = obstacle present.

Function
REQ-008 On a clk edge with rst=0 and en=1, obstacles SHALL become {obstacles[WIDTH-2:0], ins}, where ins is the computed insert bit.
REQ-009 On a clk edge with rst=0 and en=0, obstacles SHALL hold its value and rng_in SHALL be ignored.
REQ-010 With OBSTACLE_MIN_GAP_EN defined, ins SHALL equal rng_in AND (obstacles[MIN_GAP-1:0] == 0).
- An obstacle is never inserted when any of the MIN_GAP most recently shifted-in cells is occupied.
REQ-011 Without OBSTACLE_MIN_GAP_EN, ins SHALL equal rng_in.
REQ-012 The bit in obstacles[WIDTH-1] SHALL be discarded on a shift.
- Each obstacle is visible for exactly WIDTH enabled cycles.
REQ-013 Latency: rng_in sampled at edge N SHALL appear in obstacles[0] immediately after edge N; there is no extra pipeline stage.
REQ-014 obstacles SHALL be driven directly from flops, with no combinational path from any input to the output.
REQ-015 A rejected request (gap violation) SHALL be dropped, not queued for later cycles.

Reset
REQ-016 When rst=1 at a clk edge, obstacles SHALL become all zeros, regardless of en and rng_in.
REQ-017 rst SHALL take priority over en.
- A reset asserted mid-operation clears the lane on that edge.
- The first enabled edge after reset release may insert immediately.
REQ-018 No state other than obstacles SHALL exist; gap qualification derives solely from obstacles.

Configuration
REQ-019 Macro OBSTACLE_MIN_GAP_EN SHALL compile in the minimum-gap qualification of REQ-010.
- Undefined: every rng_in=1 on an enabled cycle inserts an obstacle (REQ-011).
- Undefined: MIN_GAP is unused.

Structure
REQ-020 A shared package obstacle_pkg SHALL hold:
- constants OBST_WIDTH_DEFAULT=10 and OBST_MIN_GAP_DEFAULT=2;
- typedef obst_lane_t (logic [OBST_WIDTH_DEFAULT-1:0]).
REQ-021 The insert qualification (rng_in, recent cells -> ins) SHALL be one sub-module, obstacle_spawn_gate, containing the OBSTACLE_MIN_GAP_EN conditional.
REQ-022 The shift register SHALL reside in obstacle_generator.

Verification
REQ-023 Reset: rst=1 for 1 edge with rng_in=1, en=1 -> obstacles=0000000000.
REQ-024 Hold: after obstacles=0000000001, set en=0, rng_in=1 for 3 edges -> obstacles stays 0000000001.
REQ-025 Gap (macro on, MIN_GAP=2): from zero, en=1, rng_in=1 for 4 edges -> obstacles sequence:
- 0000000001
- 0000000010
- 0000000100
- 0000001001
REQ-026 Gap off (macro undefined): from zero, en=1, rng_in=1 for 3 edges -> 0000000001, 0000000011, 0000000111.
REQ-027 Exit: single obstacle inserted, then rng_in=0 and en=1 for 10 edges:
- after 9 edges obstacles=1000000000;
- after 10 edges obstacles=0000000000.
REQ-028 Mid-run reset: obstacles=0000101001, rst=1 for one edge with en=1 -> 0000000000; next edge with rng_in=1 -> 0000000001.
